// File: rtl/perf_monitor.sv
// -----------------------------------------------------------------------------
// perf_monitor
//
// Performance monitor that snoops the CPU instruction-fetch port. While a
// measurement is running it counts cycles, non-NOP instructions fetched at a
// new PC, and NUM_EVT generic event strobes. It also decides in hardware when
// the program has finished: either the PC has stopped advancing, or the core is
// fetching NOPs while the PC stays put.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle pulse: arm, or restart, a measurement
//   clear        synchronous clear of all counters and flags, back to IDLE
//   fetch_pc     current instruction fetch address
//   fetch_instr  instruction word returned for fetch_pc
//   evt          per-cycle event strobes, counted while RUN
//   cycle_count  cycles spent in RUN
//   instr_count  non-NOP instructions fetched at a new PC
//   evt_count    flat bus, counter i at bits [i*CNT_W +: CNT_W]
//   sat          sticky saturation flags: bit0 cycle, bit1 instr, bit2+i evt i
//   state        00 IDLE, 01 RUN, 10 DONE
//   done         high while in DONE
// -----------------------------------------------------------------------------
module perf_monitor #(
  parameter int          CNT_W       = 32,
  parameter int          NUM_EVT     = 4,
  parameter int          STALL_LIMIT = 15,
  parameter int          NOP_LIMIT   = 5,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     clear,
  input  logic [31:0]              fetch_pc,
  input  logic [31:0]              fetch_instr,
  input  logic [NUM_EVT-1:0]       evt,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         instr_count,
  output logic [NUM_EVT*CNT_W-1:0] evt_count,
  output logic [NUM_EVT+1:0]       sat,
  output logic [1:0]               state,
  output logic                     done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // The stable counter must be able to exceed STALL_LIMIT by one.
  localparam int               ST_W      = $clog2(STALL_LIMIT + 2);
  localparam logic [ST_W-1:0]  STALL_LIM = ST_W'(STALL_LIMIT);
  localparam logic [ST_W-1:0]  NOP_LIM   = ST_W'(NOP_LIMIT);
  localparam logic [ST_W-1:0]  ST_ONE    = ST_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cycle_q, cycle_d;
  logic [CNT_W-1:0]              instr_q, instr_d;
  logic [NUM_EVT-1:0][CNT_W-1:0] evt_q, evt_d;
  logic [NUM_EVT+1:0]            sat_q, sat_d;
  logic [ST_W-1:0]               st_q, st_d;
  logic [ST_W-1:0]               st_inc;
  logic [31:0]                   prev_pc_q, prev_pc_d;
  logic                          prev_valid_q, prev_valid_d;
  logic                          is_nop;
  logic                          count_instr;

  // NOTE: every signal written here gets its default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cycle_d      = cycle_q;
    instr_d      = instr_q;
    evt_d        = evt_q;
    sat_d        = sat_q;
    st_d         = st_q;
    prev_pc_d    = prev_pc_q;
    prev_valid_d = prev_valid_q;
    count_instr  = 1'b0;
    is_nop       = (fetch_instr == NOP_INSTR);
    st_inc       = (&st_q) ? st_q : st_q + ST_ONE;

    if (clear || start) begin
      // clear wins over start; both wipe the whole measurement.
      state_d      = clear ? S_IDLE : S_RUN;
      cycle_d      = '0;
      instr_d      = '0;
      evt_d        = '0;
      sat_d        = '0;
      st_d         = '0;
      prev_pc_d    = '0;
      prev_valid_d = 1'b0;
    end else if (state_q == S_RUN) begin
      // Stable-PC tracking. The first RUN cycle has no previous PC to compare
      // against, so it only counts the instruction and leaves ST at zero.
      if (!prev_valid_q) begin
        count_instr = !is_nop;
      end else if (fetch_pc != prev_pc_q) begin
        if (!is_nop) begin
          count_instr = 1'b1;
          st_d        = '0;
        end else begin
          // Walking over NOPs is not progress.
          st_d = st_inc;
        end
      end else begin
        st_d = st_inc;
      end
      prev_pc_d    = fetch_pc;
      prev_valid_d = 1'b1;

      // Saturating counters; the sticky flag records an increment lost at
      // all-ones.
      cycle_d  = (&cycle_q) ? cycle_q : cycle_q + CNT_ONE;
      sat_d[0] = sat_q[0] | (&cycle_q);
      if (count_instr) begin
        instr_d  = (&instr_q) ? instr_q : instr_q + CNT_ONE;
        sat_d[1] = sat_q[1] | (&instr_q);
      end
      for (int i = 0; i < NUM_EVT; i++) begin
        if (evt[i]) begin
          evt_d[i]     = (&evt_q[i]) ? evt_q[i] : evt_q[i] + CNT_ONE;
          sat_d[i + 2] = sat_q[i + 2] | (&evt_q[i]);
        end
      end

      // Completion uses the updated stable count; this cycle's increments
      // above still land.
      if ((st_d > STALL_LIM) || (is_nop && (st_d > NOP_LIM))) begin
        state_d = S_DONE;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the values from before this edge, independent of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cycle_q      <= '0;
      instr_q      <= '0;
      evt_q        <= '0;
      sat_q        <= '0;
      st_q         <= '0;
      prev_pc_q    <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cycle_q      <= cycle_d;
      instr_q      <= instr_d;
      evt_q        <= evt_d;
      sat_q        <= sat_d;
      st_q         <= st_d;
      prev_pc_q    <= prev_pc_d;
      prev_valid_q <= prev_valid_d;
    end
  end

  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
  assign evt_count   = evt_q;
  assign sat         = sat_q;
  assign state       = state_q;
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_perf_monitor.sv
// -----------------------------------------------------------------------------
// tb_perf_monitor
//
// Scoreboard bench for perf_monitor. u_main uses the default 32-bit counters;
// u_sat uses 4-bit counters so saturation is reachable in a few cycles.
// Stimulus pushes hand-computed expected snapshots into a queue and fires
// chk_ev; an independent monitor pops and compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_perf_monitor;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] INS = 32'h0010_0093;
  localparam logic [1:0]  IDL = 2'b00;
  localparam logic [1:0]  RUN = 2'b01;
  localparam logic [1:0]  DON = 2'b10;

  logic clk;
  logic rst_n;

  // main DUT stimulus / observation
  logic         start, clear;
  logic [31:0]  fetch_pc, fetch_instr;
  logic [3:0]   evt;
  logic [31:0]  cycle_m, instr_m;
  logic [127:0] evc_m;
  logic [5:0]   sat_m;
  logic [1:0]   state_m;
  logic         done_m;

  // saturation DUT stimulus / observation
  logic         start_s, clear_s;
  logic [31:0]  pc_s, instr_s;
  logic [3:0]   evt_s;
  logic [3:0]   cycle_s, instr_cs;
  logic [15:0]  evc_s;
  logic [5:0]   sat_s;
  logic [1:0]   state_s;
  logic         done_s;

  perf_monitor u_main (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .fetch_pc(fetch_pc), .fetch_instr(fetch_instr), .evt(evt),
    .cycle_count(cycle_m), .instr_count(instr_m), .evt_count(evc_m),
    .sat(sat_m), .state(state_m), .done(done_m)
  );

  perf_monitor #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .clear(clear_s),
    .fetch_pc(pc_s), .fetch_instr(instr_s), .evt(evt_s),
    .cycle_count(cycle_s), .instr_count(instr_cs), .evt_count(evc_s),
    .sat(sat_s), .state(state_s), .done(done_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- scoreboard
  typedef struct packed {
    logic         sel;   // 0: u_main, 1: u_sat
    logic [1:0]   st;
    logic [31:0]  cyc;
    logic [31:0]  ins;
    logic [127:0] evc;
    logic [5:0]   sat;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  event  chk_ev;
  int    checks   = 0;
  int    failures = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_snap(input string nm, input logic sel,
                             input logic [1:0] st, input logic [31:0] cyc,
                             input logic [31:0] ins, input logic [127:0] evc,
                             input logic [5:0] sat);
    exp_t e;
    e.sel = sel; e.st = st; e.cyc = cyc; e.ins = ins; e.evc = evc; e.sat = sat;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    -> chk_ev;
    #1;
  endtask

  // Monitor: drains the queue each time stimulus signals a sampling point.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        if (!e.sel) begin
          check({nm, ".state"}, 128'(state_m), 128'(e.st));
          check({nm, ".done"},  128'(done_m),  128'(e.st == DON));
          check({nm, ".cycle"}, 128'(cycle_m), 128'(e.cyc));
          check({nm, ".instr"}, 128'(instr_m), 128'(e.ins));
          check({nm, ".evt"},   evc_m,         e.evc);
          check({nm, ".sat"},   128'(sat_m),   128'(e.sat));
        end else begin
          check({nm, ".state"}, 128'(state_s),  128'(e.st));
          check({nm, ".done"},  128'(done_s),   128'(e.st == DON));
          check({nm, ".cycle"}, 128'(cycle_s),  128'(e.cyc));
          check({nm, ".instr"}, 128'(instr_cs), 128'(e.ins));
          check({nm, ".evt"},   128'(evc_s),    e.evc);
          check({nm, ".sat"},   128'(sat_s),    128'(e.sat));
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  // Apply one vector at a falling edge and return at the next falling edge,
  // i.e. after the rising edge that consumed it.
  task automatic cyc(input logic [31:0] pc, input logic [31:0] ins,
                     input logic [3:0] ev, input logic st, input logic cl);
    fetch_pc = pc; fetch_instr = ins; evt = ev; start = st; clear = cl;
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0; clear = 1'b0; fetch_pc = '0; fetch_instr = NOP; evt = '0;
    start_s = 1'b0; clear_s = 1'b0; pc_s = '0; instr_s = NOP; evt_s = '0;

    // Reset state of both instances.
    #3;
    expect_snap("rst_main", 1'b0, IDL, 32'd0, 32'd0, 128'd0, 6'd0);
    expect_snap("rst_sat",  1'b1, IDL, 32'd0, 32'd0, 128'd0, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: straight-line fetch, then NOPs at advancing PCs.
    cyc(32'd0, NOP, 4'hF, 1'b1, 1'b0);
    expect_snap("t1_start", 1'b0, RUN, 32'd0, 32'd0, 128'd0, 6'd0);
    for (int i = 0; i < 10; i++) cyc(32'(i * 4), INS, 4'b0001, 1'b0, 1'b0);
    n = 0;
    while (!done_m && n < 30) begin
      cyc(32'(40 + 4 * n), NOP, 4'b0100, 1'b0, 1'b0);
      n++;
    end
    check("t1_nop_cycles", 128'(n), 128'd6);
    expect_snap("t1_done", 1'b0, DON, 32'd16, 32'd10,
                {32'd0, 32'd6, 32'd0, 32'd10}, 6'd0);
    for (int i = 0; i < 3; i++) cyc(32'h100, INS, 4'hF, 1'b0, 1'b0);
    expect_snap("t1_frozen", 1'b0, DON, 32'd16, 32'd10,
                {32'd0, 32'd6, 32'd0, 32'd10}, 6'd0);

    // T2: restart from DONE, three instructions, then PC held at 8.
    cyc(32'd0, INS, 4'hF, 1'b1, 1'b0);
    expect_snap("t2_restart", 1'b0, RUN, 32'd0, 32'd0, 128'd0, 6'd0);
    for (int i = 0; i < 3; i++) cyc(32'(i * 4), INS, 4'b0000, 1'b0, 1'b0);
    n = 0;
    while (!done_m && n < 40) begin
      cyc(32'd8, INS, 4'b0000, 1'b0, 1'b0);
      n++;
    end
    check("t2_hold_cycles", 128'(n), 128'd16);
    expect_snap("t2_done", 1'b0, DON, 32'd19, 32'd3, 128'd0, 6'd0);

    // T3: branch to 0x40 counts like a sequential fetch; evt[3] on the jump.
    cyc(32'd0, INS, 4'h0, 1'b1, 1'b0);
    cyc(32'h00, INS, 4'b0000, 1'b0, 1'b0);
    cyc(32'h04, INS, 4'b0000, 1'b0, 1'b0);
    cyc(32'h08, INS, 4'b0000, 1'b0, 1'b0);
    cyc(32'h40, INS, 4'b1000, 1'b0, 1'b0);
    cyc(32'h44, INS, 4'b0000, 1'b0, 1'b0);
    expect_snap("t3_run", 1'b0, RUN, 32'd5, 32'd5,
                {32'd1, 32'd0, 32'd0, 32'd0}, 6'd0);
    n = 0;
    while (!done_m && n < 40) begin
      cyc(32'h44, INS, 4'b0000, 1'b0, 1'b0);
      n++;
    end
    check("t3_hold_cycles", 128'(n), 128'd16);
    expect_snap("t3_done", 1'b0, DON, 32'd21, 32'd5,
                {32'd1, 32'd0, 32'd0, 32'd0}, 6'd0);

    // T4: restart in RUN, then clear+start together.
    cyc(32'd0, INS, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(32'(i * 4), INS, 4'b0010, 1'b0, 1'b0);
    expect_snap("t4_run", 1'b0, RUN, 32'd3, 32'd3,
                {32'd0, 32'd0, 32'd3, 32'd0}, 6'd0);
    cyc(32'd12, INS, 4'b0010, 1'b1, 1'b0);
    expect_snap("t4_restart_run", 1'b0, RUN, 32'd0, 32'd0, 128'd0, 6'd0);
    cyc(32'd0, INS, 4'b0010, 1'b0, 1'b0);
    cyc(32'd4, INS, 4'b0010, 1'b0, 1'b0);
    expect_snap("t4_run2", 1'b0, RUN, 32'd2, 32'd2,
                {32'd0, 32'd0, 32'd2, 32'd0}, 6'd0);
    cyc(32'd8, INS, 4'hF, 1'b1, 1'b1);
    expect_snap("t4_clear_start", 1'b0, IDL, 32'd0, 32'd0, 128'd0, 6'd0);
    for (int i = 0; i < 3; i++) cyc(32'(16 + i * 4), INS, 4'hF, 1'b0, 1'b0);
    expect_snap("t4_idle_hold", 1'b0, IDL, 32'd0, 32'd0, 128'd0, 6'd0);

    // T5: asynchronous reset between clock edges.
    cyc(32'd0, INS, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(32'(i * 4), INS, 4'b0001, 1'b0, 1'b0);
    expect_snap("t5_pre", 1'b0, RUN, 32'd3, 32'd3,
                {32'd0, 32'd0, 32'd0, 32'd3}, 6'd0);
    #1;
    rst_n = 1'b0;
    #1;
    expect_snap("t5_async", 1'b0, IDL, 32'd0, 32'd0, 128'd0, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(32'(100 + i * 4), INS, 4'hF, 1'b0, 1'b0);
    expect_snap("t5_post", 1'b0, IDL, 32'd0, 32'd0, 128'd0, 6'd0);

    // T6: 4-bit counters saturate; evt[1] held high.
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int i = 0; i < 14; i++) begin
      pc_s = 32'(i * 4); instr_s = INS; evt_s = 4'b0010;
      @(negedge clk);
    end
    expect_snap("t6_pre_sat", 1'b1, RUN, 32'hE, 32'hE, 128'h00E0, 6'd0);
    for (int i = 14; i < 20; i++) begin
      pc_s = 32'(i * 4); instr_s = INS; evt_s = 4'b0010;
      @(negedge clk);
    end
    expect_snap("t6_sat", 1'b1, RUN, 32'hF, 32'hF, 128'h00F0, 6'b001011);

    check("sb_drain", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Backstop in case a stimulus loop or wait misbehaves.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/perf_monitor.md
Name: perf_monitor

Overview:
- Synthesizable performance monitor that snoops the CPU fetch port and counts cycles, fetched non-NOP instructions and NUM_EVT generic event strobes.
- Detects program completion in hardware: the PC stops advancing, or the core is fetching NOPs while the PC is stable.
- Instantiated alongside riscv_cpu at SoC/top level. Lets benches and FPGA builds read cycle, instruction and event counts, and compute IPC, without hierarchical probing.

Parameters:
- CNT_W, 32, width of every counter.
- NUM_EVT, 4, number of generic event inputs and counters (≥1).
- STALL_LIMIT, 15, completion when stable count > STALL_LIMIT.
- NOP_LIMIT, 5, completion when the current fetch is NOP and stable count > NOP_LIMIT (NOP_LIMIT < STALL_LIMIT).
- NOP_INSTR, 32'h00000013, encoding treated as NOP.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse: arm or restart measurement.
- clear  in  1  synchronous clear of all counters and flags, returns to IDLE.
- fetch_pc  in  32  current instruction fetch address (imem_addr).
- fetch_instr  in  32  instruction word returned for fetch_pc.
- evt  in  NUM_EVT  per-cycle event strobes, counted while RUN.
- cycle_count  out  CNT_W  cycles spent in RUN.
- instr_count  out  CNT_W  non-NOP instructions fetched at a new PC.
- evt_count  out  NUM_EVT*CNT_W  flat bus, counter i at bits [i*CNT_W +: CNT_W].
- sat  out  NUM_EVT+2  sticky saturation flags: bit0 cycle, bit1 instr, bit2+i evt i.
- state  out  2  00 IDLE, 01 RUN, 10 DONE.
- done  out  1  high in DONE.

Behaviour:
- Reset (rst_n=0, asynchronous) takes effect immediately:
  - state=IDLE; all counters, sat, stable counter and prev_valid are 0; done=0.
- Priority within a cycle: clear > start > normal operation.
- clear=1: next cycle all counters/flags are 0 and state=IDLE, regardless of the current state.
- IDLE: counters hold. start=1 → zero all counters and flags, prev_valid=0, state=RUN next cycle.
- RUN, every cycle:
  - cycle_count += 1 (saturating).
  - Internal stable counter ST, width $clog2(STALL_LIMIT+2), saturating.
  - If prev_valid=0 (first RUN cycle): instr_count += 1 if fetch_instr != NOP_INSTR; ST unchanged (0).
  - Else if fetch_pc != prev_pc: if fetch_instr != NOP_INSTR then instr_count += 1 and ST' = 0; else ST' = ST+1.
  - Else (PC unchanged): ST' = ST+1.
  - prev_pc <= fetch_pc; prev_valid <= 1.
  - evt_count[i] += 1 when evt[i]=1 (saturating).
  - Completion test uses ST' (the updated value) and the current fetch_instr: ST' > STALL_LIMIT, or (fetch_instr == NOP_INSTR and ST' > NOP_LIMIT). When true, state=DONE next cycle; that cycle's increments are still applied.
- DONE: all counters frozen; done=1. start=1 → restart exactly as from IDLE. rst_n or clear → IDLE.
- start while in RUN: restart (counters zeroed, prev_valid=0, stays RUN).
- Saturation: a counter at all-ones stays at all-ones and its sat bit is set; sat bits clear only on start, clear or reset.
- Outputs are registered; a counter value reflects an event one cycle after the sampling edge.
- Evaluation in IDLE/DONE: fetch_pc and fetch_instr are ignored; evt is ignored.

Test Plan:
- Straight-line fetch: start, then PC 0,4,…,36 with 10 non-NOP words, then PC advancing over NOPs → instr_count=10; DONE entered on the 6th NOP fetch (ST'=6); cycle_count=16.
- Stall then halt: 3 instructions, then PC held at 8 with a non-NOP word → DONE when ST'=16; instr_count=3, cycle_count=19.
- Branch: PC 0,4,8,0x40,0x44, all non-NOP, then hold → instr_count=5; a non-sequential PC counts the same as a sequential one.
- Events and saturation: CNT_W=4, evt[1]=1 for 20 RUN cycles → evt_count[1]=4'hF, sat[3]=1, cycle_count=4'hF, sat[0]=1, other evt counters 0.
- Priority: clear and start asserted together in RUN → IDLE, counters 0. start alone in DONE → RUN with counters zeroed.
- Async reset mid-RUN: drop rst_n between clock edges → state=00, all counters 0 before the next clk edge; stays IDLE after release until start.
